// File: rtl/data_memory_responder.sv
// Data-port memory responder: serves core loads/stores from a word RAM after
// a fixed number of wait states, answering with a one-cycle ready pulse.
module data_memory_responder #(
  parameter int unsigned memory_depth = 64,
  parameter logic [31:0] base_address = 32'h1001_0000,
  parameter int unsigned wait_cycles  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] data_address,
  input  logic [31:0] writedata,
  output logic [31:0] received_data,
  output logic        ready,
  output logic        busy,
  output logic        addr_error
);

  localparam int unsigned IW = (memory_depth > 1) ? $clog2(memory_depth) : 1;
  localparam int unsigned CW = (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  // With no wait states an accepted request goes straight to the response
  localparam logic [1:0] ST_FIRST = (wait_cycles > 0) ? ST_WAIT : ST_RESP;

  logic [1:0]    state_r;
  logic [1:0]    next_s;
  logic [CW-1:0] cnt_r;
  logic          rd_r;
  logic          wr_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   rdata_r;
  logic          ready_r;
  logic          busy_r;
  logic          err_out_r;
  logic [31:0]   mem_r [memory_depth];

  logic [31:0]   dec_addr_s;
  logic          dec_rd_s;
  logic          dec_wr_s;
  logic          err_s;
  logic [IW-1:0] idx_s;

  // Full 30-bit index compare, so out-of-range addresses never alias into the RAM
  function automatic logic addr_bad(input logic [31:0] a);
    logic [31:0] off;
    off = a - base_address;
    return (a < base_address) || (off[1:0] != 2'b00) ||
           ((off >> 2) >= 32'(memory_depth));
  endfunction

  // Decode the incoming request in IDLE (zero-wait path), the latched one otherwise
  always_comb begin
    dec_addr_s = addr_r;
    dec_rd_s   = rd_r;
    dec_wr_s   = wr_r;
    if (state_r == ST_IDLE) begin
      dec_addr_s = data_address;
      dec_rd_s   = memread;
      dec_wr_s   = memwrite;
    end else begin
      dec_addr_s = addr_r;
      dec_rd_s   = rd_r;
      dec_wr_s   = wr_r;
    end
    err_s = addr_bad(dec_addr_s) || (dec_rd_s && dec_wr_s);
    idx_s = IW'((dec_addr_s - base_address) >> 2);
  end

  // Next-state logic for IDLE -> WAIT -> RESP -> IDLE
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (memread || memwrite) begin
          next_s = ST_FIRST;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= CW'(1'b1)) begin
          next_s = ST_RESP;
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_RESP: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // State, request latch, wait counter and registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      rd_r      <= 1'b0;
      wr_r      <= 1'b0;
      addr_r    <= 32'h0;
      wdata_r   <= 32'h0;
      rdata_r   <= 32'h0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
      err_out_r <= 1'b0;
    end else begin
      state_r   <= next_s;
      busy_r    <= (next_s != ST_IDLE);
      ready_r   <= (next_s == ST_RESP);
      err_out_r <= (next_s == ST_RESP) && err_s;
      if (state_r == ST_IDLE && (memread || memwrite)) begin
        rd_r    <= memread;
        wr_r    <= memwrite;
        addr_r  <= data_address;
        wdata_r <= writedata;
        cnt_r   <= CW'(wait_cycles);
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - CW'(1'b1);
      end
      // Response data is captured on entry to RESP so it is valid with ready
      if (next_s == ST_RESP && (err_s || dec_rd_s)) begin
        rdata_r <= err_s ? 32'h0 : mem_r[idx_s];
      end
    end
  end

  // RAM write commits at the edge that ends a good write response
  always_ff @(posedge clk) begin
    if (!reset && state_r == ST_RESP && wr_r && !rd_r && !err_s) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

  assign received_data = rdata_r;
  assign ready         = ready_r;
  assign busy          = busy_r;
  assign addr_error    = err_out_r;

endmodule

// File: tb/tb_data_memory_responder.sv
// Table-driven bench for data_memory_responder: one instance with two wait
// states, one with none, plus hand sequences for reset and back-to-back.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread2, memwrite2, memread0, memwrite0;
  logic [31:0] addr2, wdata2, addr0, wdata0;
  logic [31:0] rdata2, rdata0;
  logic        ready2, busy2, err2, ready0, busy0, err0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.memory_depth(64), .base_address(32'h1001_0000), .wait_cycles(2)) dut (
    .clk(clk), .reset(reset), .memread(memread2), .memwrite(memwrite2),
    .data_address(addr2), .writedata(wdata2), .received_data(rdata2),
    .ready(ready2), .busy(busy2), .addr_error(err2)
  );

  data_memory_responder #(.memory_depth(64), .base_address(32'h1001_0000), .wait_cycles(0)) dut0 (
    .clk(clk), .reset(reset), .memread(memread0), .memwrite(memwrite0),
    .data_address(addr0), .writedata(wdata0), .received_data(rdata0),
    .ready(ready0), .busy(busy0), .addr_error(err0)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;
    logic        chk_data;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One access on instance sel (0: wait 2, 1: wait 0); exp_lat counts edges from drive to ready
  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_data, input logic chk_data,
                        input string tag);
    int  lat;
    int  nbusy;
    int  w;
    logic seen;
    w = (sel == 0) ? 2 : 0;
    if (sel == 0) begin
      memread2 = rd; memwrite2 = wr; addr2 = addr; wdata2 = wdata;
    end else begin
      memread0 = rd; memwrite0 = wr; addr0 = addr; wdata0 = wdata;
    end
    lat = 0; nbusy = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (((sel == 0) ? busy2 : busy0) == 1'b0) nbusy++;
      seen = (sel == 0) ? ready2 : ready0;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy_low_cycles"}, 32'(nbusy), 32'(exp_lat - 1 - w));
    chk({tag, " addr_error"}, 32'((sel == 0) ? err2 : err0), 32'(exp_err));
    if (chk_data) chk({tag, " received_data"}, (sel == 0) ? rdata2 : rdata0, exp_data);
    if (sel == 0) begin
      memread2 = 1'b0; memwrite2 = 1'b0;
    end else begin
      memread0 = 1'b0; memwrite0 = 1'b0;
    end
  endtask

  task automatic idle_chk(input int sel, input string tag);
    @(posedge clk); #1;
    chk({tag, " idle ready"}, 32'((sel == 0) ? ready2 : ready0), 32'd0);
    chk({tag, " idle busy"}, 32'((sel == 0) ? busy2 : busy0), 32'd0);
    chk({tag, " idle addr_error"}, 32'((sel == 0) ? err2 : err0), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h1001_0008, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h1001_0000, 32'hA5A5_0000, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h1001_0014, 32'h5555_5555, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h1001_00FC, 32'h6363_6363, 1'b0, 32'h0,         1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h1001_0006, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h1001_0100, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'h1000_FFFC, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 1'b1, 32'h1001_0000, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h1001_0100, 32'h7777_7777, 1'b1, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h1001_0000, 32'h0,         1'b0, 32'hA5A5_0000, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'h1001_0004, 32'h0BAD_F00D, 1'b0, 32'hA5A5_0000, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'h1001_00FC, 32'h0,         1'b0, 32'h6363_6363, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'h1001_0004, 32'h0,         1'b0, 32'h0BAD_F00D, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 32'h1001_0008, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 32'h1001_0010, 32'h1111_2222, 1'b0, 32'hDEAD_BEEF, 1'b1};

    reset = 1'b1;
    memread2 = 1'b0; memwrite2 = 1'b0; addr2 = 32'h0; wdata2 = 32'h0;
    memread0 = 1'b0; memwrite0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 32'(ready2), 32'd0);
    chk("reset busy", 32'(busy2), 32'd0);
    chk("reset addr_error", 32'(err2), 32'd0);
    chk("reset received_data", rdata2, 32'h0);
    chk("reset ready0", 32'(ready0), 32'd0);
    chk("reset busy0", 32'(busy0), 32'd0);
    reset = 1'b0;
    idle_chk(0, "post_reset");

    for (int i = 0; i < 16; i++) begin
      access(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 3,
             vecs[i].exp_err, vecs[i].exp_data, vecs[i].chk_data, $sformatf("vec%0d", i));
      idle_chk(0, $sformatf("vec%0d", i));
    end

    // Reset while a write to word 5 is waiting: write must be discarded
    memwrite2 = 1'b1; addr2 = 32'h1001_0014; wdata2 = 32'h1234_5678;
    @(posedge clk); #1;
    chk("pre_reset busy", 32'(busy2), 32'd1);
    reset = 1'b1; memwrite2 = 1'b0;
    @(posedge clk); #1;
    chk("midreset ready", 32'(ready2), 32'd0);
    chk("midreset busy", 32'(busy2), 32'd0);
    chk("midreset addr_error", 32'(err2), 32'd0);
    chk("midreset received_data", rdata2, 32'h0);
    reset = 1'b0;
    idle_chk(0, "after_midreset");
    access(0, 1'b1, 1'b0, 32'h1001_0014, 32'h0, 3, 1'b0, 32'h5555_5555, 1'b1, "word5_after_reset");
    idle_chk(0, "word5_read");

    // Zero-wait instance: load words 0..2, then three back-to-back reads
    for (int i = 0; i < 3; i++) begin
      access(1, 1'b0, 1'b1, 32'h1001_0000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1,
             1'b0, 32'h0, 1'b0, $sformatf("w0_write%0d", i));
      idle_chk(1, $sformatf("w0_write%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      access(1, 1'b1, 1'b0, 32'h1001_0000 + 32'(i * 4), 32'h0, (i == 0) ? 1 : 2,
             1'b0, 32'hC0DE_0000 + 32'(i), 1'b1, $sformatf("b2b_read%0d", i));
    end
    idle_chk(1, "b2b_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Memory-side responder for the processor core's data port. It accepts the core's memread/memwrite, data_address and writedata requests and serves them from an internal word-addressed RAM after a configurable number of wait states. It returns read data on received_data together with a one-cycle ready pulse, which the core uses as its stall-release handshake. The block sits between the core's data-memory outputs and its received_data input.

Parameters:
memory_depth, 64, number of 32-bit words in the RAM.
base_address, 32'h1001_0000, byte address that maps to word 0.
wait_cycles, 2, extra cycles inserted between request acceptance and the response (0 allowed).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
memread  input  1  read request from core.
memwrite  input  1  write request from core.
data_address  input  32  byte address of the access.
writedata  input  32  store data.
received_data  output  32  read data returned to core.
ready  output  1  one-cycle pulse: the current access is complete.
busy  output  1  high whenever the FSM is not IDLE.
addr_error  output  1  qualifies ready: the access was rejected.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, ready 0, busy 0, addr_error 0, received_data 32'h0, wait counter 0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If memread or memwrite is high at a rising edge, latch op, address and writedata, and load counter = wait_cycles.
  - Next state is WAIT if wait_cycles > 0, otherwise RESP.
  - With no request, stay in IDLE.
- WAIT: decrement the counter every cycle. When the counter reaches 1, the next state is RESP. Inputs are ignored in WAIT.
- RESP:
  - ready = 1 for exactly this cycle.
  - For a write, the RAM is written at the edge that ends RESP.
  - Next state is always IDLE.
- Latency: a request first seen in IDLE during cycle t is answered with ready high in cycle t+1+wait_cycles.
- Handshake: the core holds its request until ready and drives its next request (or none) in the cycle after ready. IDLE treats any request present then as new, so back-to-back accesses cost wait_cycles+2 cycles each.
- Address decode, computed from the latched address:
  - offset = address - base_address.
  - index = offset[31:2].
  - Error if address < base_address, or offset[1:0] != 0, or index >= memory_depth.
- Conflicting request: memread and memwrite both high is also an error.
- On error:
  - No RAM access.
  - ready still pulses at the normal latency.
  - addr_error = 1 in the same cycle as ready.
  - received_data is forced to 0.
- addr_error is 0 in every other cycle.
- received_data:
  - Registered.
  - Updated only at a read response: RAM word, or 0 on error.
  - Valid in the ready cycle and held until the next read response.
  - Writes do not change received_data.
- busy = (state != IDLE), registered with the state.
- Reset mid-operation: the FSM returns to IDLE and any pending write is discarded (RAM is unchanged). ready, busy and addr_error are 0 in the cycle after reset.
- Widths: index is compared at full 30-bit width, so there is no wrap-around aliasing. The RAM index uses $clog2(memory_depth) bits.

Test Plan:
- Write then read, wait_cycles=2:
  - memwrite at 0x1001_0008 with 0xDEAD_BEEF: ready in cycle t+3, addr_error 0.
  - Then memread at the same address: received_data = 0xDEAD_BEEF with ready, busy high for cycles t+1..t+3.
- wait_cycles=0 back-to-back: three consecutive reads of words 0, 1, 2, each presented the cycle after ready → ready every 2nd cycle, correct data each time.
- Misaligned read 0x1001_0006 and out-of-range read 0x1001_0100 (depth 64) → ready with addr_error 1, received_data 0, RAM unchanged.
- Address below base (0x1000_FFFC), and memread plus memwrite together at 0x1001_0000 → addr_error 1; a later read of word 0 returns its prior value.
- Reset asserted in WAIT during a write of 0x1234_5678 to word 5 → next cycle state IDLE, ready/busy 0; a subsequent read of word 5 returns the old value.
- Read response then write: received_data keeps the read value through the write's ready pulse.
